d_latch: RTL and testbench

//   Clock-synchronous emulation of a level-sensitive D latch with parameterised width.

---
 rtl/d_latch.sv | 114 +++++++++++
 tb/tb_d_latch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/d_latch.sv
`default_nettype none
// ============================================================================
//  Module      : d_latch
//  Description : Clock-synchronous emulation of a level-sensitive D latch.
//                While the effective enable is high, q follows the effective
//                data one clock later. While it is low, q holds. Optional
//                input synchroniser stages and open/close/change event
//                outputs, plus a saturating counter of closed cycles.
//  Ports       : clk         - single clock, rising edge
//                rst         - synchronous reset, active-high
//                d           - data input (WIDTH)
//                en          - latch enable (1 = transparent, 0 = hold)
//                q           - latched data, registered (WIDTH)
//                is_open     - registered copy of the effective enable
//                open_pulse  - one-cycle pulse on effective enable rise
//                close_pulse - one-cycle pulse on effective enable fall
//                q_changed   - one-cycle pulse when q took a new value
//                hold_cycles - closed cycles since last close, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module d_latch #(
    parameter int                 WIDTH       = 1,
    parameter int                 SYNC_STAGES = 0,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter int                 CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      d,
    input  logic                  en,
    output logic [WIDTH-1:0]      q,
    output logic                  is_open,
    output logic                  open_pulse,
    output logic                  close_pulse,
    output logic                  q_changed,
    output logic [CNT_WIDTH-1:0]  hold_cycles
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    // Effective (optionally synchronised) inputs
    logic [WIDTH-1:0] w_d_e;
    logic             w_en_e;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign w_d_e  = d;
            assign w_en_e = en;
        end else begin : g_sync
            // d and en travel through identical pipelines so they stay aligned
            logic [WIDTH-1:0] r_d_sync  [SYNC_STAGES];
            logic             r_en_sync [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_d_sync[i]  <= '0;
                        r_en_sync[i] <= 1'b0;
                    end
                end else begin
                    r_d_sync[0]  <= d;
                    r_en_sync[0] <= en;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_d_sync[i]  <= r_d_sync[i-1];
                        r_en_sync[i] <= r_en_sync[i-1];
                    end
                end
            end

            assign w_d_e  = r_d_sync[SYNC_STAGES-1];
            assign w_en_e = r_en_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Edge of the effective enable, judged against the previous cycle's state
    logic w_opening;
    logic w_closing;

    assign w_opening = w_en_e & ~is_open;
    assign w_closing = ~w_en_e & is_open;

    always_ff @(posedge clk) begin
        if (rst) begin
            q           <= RESET_VALUE;
            is_open     <= 1'b0;
            open_pulse  <= 1'b0;
            close_pulse <= 1'b0;
            q_changed   <= 1'b0;
            hold_cycles <= '0;
        end else begin
            is_open     <= w_en_e;
            open_pulse  <= w_opening;
            close_pulse <= w_closing;
            // Compared against the current q, so a repeat of the held value
            // does not count as a change
            q_changed   <= w_en_e && (w_d_e != q);

            if (w_en_e) begin
                q <= w_d_e;
            end

            // The closing edge restarts the count; further closed cycles
            // increment it; open cycles leave the last count visible.
            if (w_closing) begin
                hold_cycles <= '0;
            end else if (!w_en_e && (hold_cycles != C_CNT_MAX)) begin
                hold_cycles <= hold_cycles + C_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_d_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_latch
//  Description : Self-checking bench for d_latch. Two instances (no sync
//                stages / two sync stages) are driven with the same directed
//                and random stimulus and compared every cycle against a
//                behavioural model built from an input history.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_latch;

    localparam int C_W      = 8;
    localparam int C_HIST   = 4096;

    logic           clk;
    logic           rst;
    logic [C_W-1:0] d;
    logic           en;

    logic [C_W-1:0] q0, q2;
    logic           open0, open2, op0, op2, cp0, cp2, qc0, qc2;
    logic [3:0]     hold0;
    logic [15:0]    hold2;

    d_latch #(
        .WIDTH(C_W), .SYNC_STAGES(0), .RESET_VALUE(8'h00), .CNT_WIDTH(4)
    ) u_dut0 (
        .clk(clk), .rst(rst), .d(d), .en(en),
        .q(q0), .is_open(open0), .open_pulse(op0), .close_pulse(cp0),
        .q_changed(qc0), .hold_cycles(hold0)
    );

    d_latch #(
        .WIDTH(C_W), .SYNC_STAGES(2), .RESET_VALUE(8'h81), .CNT_WIDTH(16)
    ) u_dut2 (
        .clk(clk), .rst(rst), .d(d), .en(en),
        .q(q2), .is_open(open2), .open_pulse(op2), .close_pulse(cp2),
        .q_changed(qc2), .hold_cycles(hold2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: inputs of every edge are recorded; the effective
    // input at edge k is the input of edge k-S, or 0 if that edge predates
    // the run or a reset happened at any edge in [k-S, k-1].
    // ------------------------------------------------------------------
    logic [C_W-1:0] h_d   [C_HIST];
    logic           h_en  [C_HIST];
    logic           h_rst [C_HIST];
    int             cyc = 0;

    int             m_stages [2] = '{0, 2};
    int             m_max    [2] = '{15, 65535};
    int             m_rv     [2] = '{8'h00, 8'h81};
    int             m_q      [2];
    int             m_hold   [2];
    bit             m_open   [2];
    bit             m_op     [2];
    bit             m_cp     [2];
    bit             m_qc     [2];

    task automatic model_edge(input int i, input int k);
        int  s;
        int  de;
        bit  ee;
        bit  cleared;
        s       = m_stages[i];
        cleared = (k - s) < 0;
        for (int j = k - s; j < k; j++)
            if (j >= 0 && h_rst[j]) cleared = 1;
        de = cleared ? 0 : int'(h_d[k-s]);
        ee = cleared ? 1'b0 : h_en[k-s];

        if (h_rst[k]) begin
            m_q[i] = m_rv[i]; m_open[i] = 0; m_op[i] = 0;
            m_cp[i] = 0; m_qc[i] = 0; m_hold[i] = 0;
        end else begin
            m_op[i] = ee && !m_open[i];
            m_cp[i] = !ee && m_open[i];
            m_qc[i] = ee && (de != m_q[i]);
            if (m_cp[i])       m_hold[i] = 0;
            else if (!ee)      m_hold[i] = (m_hold[i] < m_max[i]) ? m_hold[i] + 1 : m_max[i];
            if (ee)            m_q[i] = de;
            m_open[i] = ee;
        end
    endtask

    // One clock edge: record inputs, advance the model, then compare both DUTs
    task automatic step();
        @(posedge clk);
        if (cyc >= C_HIST) begin
            $display("FAIL history: cycle %0d exceeds bench history %0d", cyc, C_HIST);
            $fatal(1, "history overflow");
        end
        h_d[cyc] = d; h_en[cyc] = en; h_rst[cyc] = rst;
        model_edge(0, cyc);
        model_edge(1, cyc);
        cyc++;
        #1;
        check("s0.q",      32'(q0),    32'(m_q[0]));
        check("s0.open",   32'(open0), 32'(m_open[0]));
        check("s0.open_p", 32'(op0),   32'(m_op[0]));
        check("s0.close_p",32'(cp0),   32'(m_cp[0]));
        check("s0.qchg",   32'(qc0),   32'(m_qc[0]));
        check("s0.hold",   32'(hold0), 32'(m_hold[0]));
        check("s2.q",      32'(q2),    32'(m_q[1]));
        check("s2.open",   32'(open2), 32'(m_open[1]));
        check("s2.open_p", 32'(op2),   32'(m_op[1]));
        check("s2.close_p",32'(cp2),   32'(m_cp[1]));
        check("s2.qchg",   32'(qc2),   32'(m_qc[1]));
        check("s2.hold",   32'(hold2), 32'(m_hold[1]));
    endtask

    initial begin
        rst = 1'b1; d = 8'h01; en = 1'b1;

        // Reset held with d/en active
        repeat (3) step();
        check("rst.q0",    32'(q0),    32'h00);
        check("rst.q2",    32'(q2),    32'h81);
        check("rst.open0", 32'(open0), 32'h0);
        check("rst.hold0", 32'(hold0), 32'h0);

        // Transparent: 0x00 then 0xA5, one-cycle latency and change pulse
        rst = 1'b0; en = 1'b1; d = 8'h00;
        repeat (2) step();
        d = 8'hA5;
        step();
        check("t2.q",    32'(q0),  32'hA5);
        check("t2.qchg", 32'(qc0), 32'h1);
        step();
        check("t2.qchg_clr", 32'(qc0), 32'h0);

        // Close with 0x3C, then d changes while closed
        d = 8'h3C;
        repeat (2) step();
        en = 1'b0;
        step();
        check("t3.close_p", 32'(cp0), 32'h1);
        d = 8'hFF;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("t3.hold_cnt", 32'(hold0), 32'(i));
        end
        check("t3.q_held", 32'(q0), 32'h3C);

        // en toggled every two cycles while d walks 0..4
        for (int i = 0; i < 10; i++) begin
            en = ((i / 2) % 2) == 0;
            d  = 8'(i / 2);
            step();
        end
        en = 1'b0;
        repeat (3) step();
        check("t4.q_last", 32'(q0), 32'h04);

        // Two sync stages: step 0->1 reaches q three cycles later
        en = 1'b1; d = 8'h00;
        repeat (5) step();
        d = 8'h01;
        step();
        step();
        check("t5.q_at2", 32'(q2), 32'h00);
        step();
        check("t5.q_at3", 32'(q2), 32'h01);

        // Reset while open, then reopen
        d = 8'h5A; en = 1'b1; rst = 1'b1;
        step();
        check("t6.q_rst", 32'(q0), 32'h00);
        rst = 1'b0;
        step();
        check("t6.q_reopen", 32'(q0), 32'h5A);
        check("t6.open_p",   32'(op0), 32'h1);

        // Long close drives the 4-bit counter into saturation
        en = 1'b0;
        repeat (22) step();
        check("sat.hold0", 32'(hold0), 32'hF);

        // Random traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) en = ~en;
            if ($urandom_range(0, 1) == 0) d = 8'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound in case the clock or a step stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
